// File: rtl/sisc_pkg.sv
// ============================================================================
// sisc_pkg : shared opcodes, sequencer states and control encodings for SISC
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package sisc_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ALU = 4'h1;
  localparam logic [3:0] OP_BRA = 4'h2;
  localparam logic [3:0] OP_LOD = 4'h3;
  localparam logic [3:0] OP_STR = 4'h4;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WBACK  = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [1:0] ALU_ADDR = 2'b00;
  localparam logic [1:0] ALU_BRA  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;

  localparam logic WB_ALU = 1'b0;
  localparam logic WB_MEM = 1'b1;

  // An all-zero condition mask means "branch always".
  function automatic logic bra_taken(input logic [3:0] mask, input logic [3:0] flags);
    return (mask == 4'h0) || ((mask & flags) != 4'h0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wait_timer.sv
// ============================================================================
// mem_wait_timer : clear/enable wait counter with terminal flag at WAIT_MAX
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module mem_wait_timer #(
  parameter int WAIT_MAX = 15,
  parameter int WIDTH    = $clog2(WAIT_MAX + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic term
);

  logic [WIDTH-1:0] r_count;

  assign term = (r_count == WIDTH'(WAIT_MAX));

  // Saturates at the terminal value so the flag cannot wrap away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && !term) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sisc_seq.sv
// ============================================================================
// sisc_seq : multi-cycle SISC instruction sequencer with bounded memory wait
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module sisc_seq
  import sisc_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_f,
  input  logic [3:0] opcode,
  input  logic [3:0] mm,
  input  logic [3:0] stat,
  input  logic       dm_ack,
  output logic       ir_load,
  output logic       pc_write,
  output logic       pc_sel,
  output logic       rf_we,
  output logic       wb_sel,
  output logic       rb_sel,
  output logic [1:0] alu_op,
  output logic       stat_en,
  output logic       dm_req,
  output logic       dm_we,
  output logic       halted,
  output logic       fault
);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_op;
  logic [3:0] r_mm;
  logic       r_fault;
  logic       w_term;

  logic       w_ir_load, w_pc_write, w_pc_sel, w_rf_we, w_wb_sel, w_rb_sel;
  logic [1:0] w_alu_op;
  logic       w_stat_en, w_dm_req, w_dm_we;

  mem_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait (
    .clk   (clk),
    .rst_n (rst_f),
    .clr   (r_state != S_MEM),
    .en    ((r_state == S_MEM) && !dm_ack),
    .term  (w_term)
  );

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_state <= S_FETCH;
      r_op    <= OP_NOP;
      r_mm    <= 4'h0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_op <= opcode;
        r_mm <= mm;
      end
      if ((r_state == S_MEM) && !dm_ack && w_term) begin
        r_fault <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_ir_load  = 1'b0;
    w_pc_write = 1'b0;
    w_pc_sel   = 1'b0;
    w_rf_we    = 1'b0;
    w_wb_sel   = WB_ALU;
    w_rb_sel   = 1'b0;
    w_alu_op   = ALU_ADDR;
    w_stat_en  = 1'b0;
    w_dm_req   = 1'b0;
    w_dm_we    = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_ir_load  = 1'b1;
        w_pc_write = 1'b1;
        w_next     = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_ALU, OP_BRA, OP_LOD, OP_STR: w_next = S_EXEC;
          OP_HLT:                         w_next = S_HALT;
          default:                        w_next = S_FETCH;
        endcase
      end
      S_EXEC: begin
        case (r_op)
          OP_ALU: begin
            w_alu_op  = ALU_FUNC;
            w_stat_en = 1'b1;
            w_next    = S_WBACK;
          end
          OP_LOD, OP_STR: begin
            w_alu_op = ALU_ADDR;
            w_next   = S_MEM;
          end
          OP_BRA: begin
            w_alu_op = ALU_BRA;
            if (bra_taken(r_mm, stat)) begin
              w_pc_write = 1'b1;
              w_pc_sel   = 1'b1;
            end
            w_next = S_FETCH;
          end
          default: w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        w_dm_req = 1'b1;
        w_dm_we  = (r_op == OP_STR);
        w_rb_sel = (r_op == OP_STR);
        // Ack takes priority over the timeout on the same edge.
        if (dm_ack) begin
          w_next = (r_op == OP_LOD) ? S_WBACK : S_FETCH;
        end else if (w_term) begin
          w_next = S_HALT;
        end
      end
      S_WBACK: begin
        w_rf_we  = 1'b1;
        w_wb_sel = (r_op == OP_LOD) ? WB_MEM : WB_ALU;
        w_next   = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  // Reset forces every output low, including the FETCH strobes of the reset state.
  assign ir_load  = rst_f & w_ir_load;
  assign pc_write = rst_f & w_pc_write;
  assign pc_sel   = rst_f & w_pc_sel;
  assign rf_we    = rst_f & w_rf_we;
  assign wb_sel   = rst_f & w_wb_sel;
  assign rb_sel   = rst_f & w_rb_sel;
  assign alu_op   = rst_f ? w_alu_op : 2'b00;
  assign stat_en  = rst_f & w_stat_en;
  assign dm_req   = rst_f & w_dm_req;
  assign dm_we    = rst_f & w_dm_we;
  assign halted   = rst_f & (r_state == S_HALT);
  assign fault    = rst_f & r_fault;

endmodule

`default_nettype wire

// File: tb/tb_sisc_seq.sv
// ============================================================================
// tb_sisc_seq : cycle-by-cycle scoreboard bench for the sisc_seq sequencer
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module tb_sisc_seq;

  logic       clk = 1'b0;
  logic       rst_f;
  logic [3:0] opcode, mm, stat;
  logic       dm_ack;
  logic       ir_load, pc_write, pc_sel, rf_we, wb_sel, rb_sel;
  logic [1:0] alu_op;
  logic       stat_en, dm_req, dm_we, halted, fault;
  logic [12:0] outs;

  always #5 clk = ~clk;

  sisc_seq #(.WAIT_MAX(15)) dut (
    .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat), .dm_ack(dm_ack),
    .ir_load(ir_load), .pc_write(pc_write), .pc_sel(pc_sel), .rf_we(rf_we),
    .wb_sel(wb_sel), .rb_sel(rb_sel), .alu_op(alu_op), .stat_en(stat_en),
    .dm_req(dm_req), .dm_we(dm_we), .halted(halted), .fault(fault)
  );

  // {ir_load,pc_write,pc_sel,rf_we,wb_sel,rb_sel,alu_op[1:0],stat_en,dm_req,dm_we,halted,fault}
  assign outs = {ir_load, pc_write, pc_sel, rf_we, wb_sel, rb_sel, alu_op,
                 stat_en, dm_req, dm_we, halted, fault};

  localparam logic [12:0] O_NONE    = 13'h0000;
  localparam logic [12:0] O_FETCH   = 13'h1800;
  localparam logic [12:0] O_ALU_EX  = 13'h0050;
  localparam logic [12:0] O_ALU_WB  = 13'h0200;
  localparam logic [12:0] O_BRA_T   = 13'h0C20;
  localparam logic [12:0] O_BRA_N   = 13'h0020;
  localparam logic [12:0] O_LOD_MEM = 13'h0008;
  localparam logic [12:0] O_STR_MEM = 13'h008C;
  localparam logic [12:0] O_LOD_WB  = 13'h0300;
  localparam logic [12:0] O_HALT    = 13'h0002;
  localparam logic [12:0] O_FAULT   = 13'h0003;

  logic [12:0] exp_q[$];
  logic [12:0] got_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // One clock cycle: drive inputs after the falling edge, record expected and observed.
  task automatic cyc(input logic r, input logic [3:0] op, input logic [3:0] m,
                     input logic [3:0] st, input logic ack, input logic [12:0] e);
    @(negedge clk);
    rst_f = r; opcode = op; mm = m; stat = st; dm_ack = ack;
    exp_q.push_back(e);
    #1;
    got_q.push_back(outs);
  endtask

  task automatic test_reset();
    logic [12:0] e, g;
    cyc(0, 4'h1, 4'h0, 4'h0, 1'b0, O_NONE);
    cyc(0, 4'h1, 4'h0, 4'h0, 1'b1, O_NONE);
    cyc(0, 4'h3, 4'h0, 4'h0, 1'b0, O_NONE);
    cyc(1, 4'h0, 4'h0, 4'h0, 1'b0, O_FETCH);
    cyc(1, 4'h0, 4'h0, 4'h0, 1'b0, O_NONE);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL reset c%0d: got %h expected %h", i, g, e); end
    end
  endtask

  task automatic test_alu();
    logic [12:0] e, g;
    cyc(1, 4'h0, 4'h0, 4'h0, 1'b0, O_FETCH);
    cyc(1, 4'h1, 4'h2, 4'h0, 1'b0, O_NONE);
    cyc(1, 4'h4, 4'hF, 4'h0, 1'b1, O_ALU_EX);  // IR change after DECODE ignored
    cyc(1, 4'h3, 4'hF, 4'h0, 1'b0, O_ALU_WB);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL alu c%0d: got %h expected %h", i, g, e); end
    end
  endtask

  task automatic test_branch();
    logic [12:0] e, g;
    cyc(1, 4'h0, 4'h0, 4'h0, 1'b0, O_FETCH);
    cyc(1, 4'h2, 4'h4, 4'h0, 1'b0, O_NONE);
    cyc(1, 4'h0, 4'h0, 4'h4, 1'b0, O_BRA_T);
    cyc(1, 4'h0, 4'h0, 4'h0, 1'b0, O_FETCH);
    cyc(1, 4'h2, 4'h4, 4'h4, 1'b0, O_NONE);
    cyc(1, 4'h2, 4'hF, 4'h2, 1'b0, O_BRA_N);
    cyc(1, 4'h0, 4'h0, 4'h0, 1'b0, O_FETCH);
    cyc(1, 4'h2, 4'h0, 4'h0, 1'b0, O_NONE);
    cyc(1, 4'h2, 4'h0, 4'h0, 1'b0, O_BRA_T);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL branch c%0d: got %h expected %h", i, g, e); end
    end
  endtask

  task automatic test_load();
    logic [12:0] e, g;
    cyc(1, 4'h0, 4'h0, 4'h0, 1'b1, O_FETCH);
    cyc(1, 4'h3, 4'h0, 4'h0, 1'b1, O_NONE);
    cyc(1, 4'h3, 4'h0, 4'h0, 1'b1, O_NONE);
    for (int k = 0; k < 3; k++) cyc(1, 4'h3, 4'h0, 4'h0, 1'b0, O_LOD_MEM);
    cyc(1, 4'h3, 4'h0, 4'h0, 1'b1, O_LOD_MEM);
    cyc(1, 4'h3, 4'h0, 4'h0, 1'b1, O_LOD_WB);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL load c%0d: got %h expected %h", i, g, e); end
    end
  endtask

  task automatic test_store();
    logic [12:0] e, g;
    cyc(1, 4'h0, 4'h0, 4'h0, 1'b0, O_FETCH);
    cyc(1, 4'h4, 4'h0, 4'h0, 1'b0, O_NONE);
    cyc(1, 4'h4, 4'h0, 4'h0, 1'b0, O_NONE);
    cyc(1, 4'h4, 4'h0, 4'h0, 1'b1, O_STR_MEM);
    // Longest legal wait: ack arrives on the edge the counter sits at WAIT_MAX.
    cyc(1, 4'h0, 4'h0, 4'h0, 1'b0, O_FETCH);
    cyc(1, 4'h4, 4'h0, 4'h0, 1'b0, O_NONE);
    cyc(1, 4'h4, 4'h0, 4'h0, 1'b0, O_NONE);
    for (int k = 0; k < 15; k++) cyc(1, 4'h4, 4'h0, 4'h0, 1'b0, O_STR_MEM);
    cyc(1, 4'h4, 4'h0, 4'h0, 1'b1, O_STR_MEM);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL store c%0d: got %h expected %h", i, g, e); end
    end
  endtask

  task automatic test_nop();
    logic [12:0] e, g;
    cyc(1, 4'h0, 4'h0, 4'h0, 1'b0, O_FETCH);
    cyc(1, 4'h0, 4'h0, 4'h0, 1'b1, O_NONE);
    cyc(1, 4'h0, 4'h0, 4'h0, 1'b0, O_FETCH);
    cyc(1, 4'h9, 4'h3, 4'h0, 1'b0, O_NONE);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL nop c%0d: got %h expected %h", i, g, e); end
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [12:0] e, g;
    cyc(1, 4'h0, 4'h0, 4'h0, 1'b0, O_FETCH);
    cyc(1, 4'h3, 4'h0, 4'h0, 1'b0, O_NONE);
    cyc(1, 4'h3, 4'h0, 4'h0, 1'b0, O_NONE);
    cyc(1, 4'h3, 4'h0, 4'h0, 1'b0, O_LOD_MEM);
    cyc(1, 4'h3, 4'h0, 4'h0, 1'b0, O_LOD_MEM);
    cyc(0, 4'h3, 4'h0, 4'h0, 1'b0, O_NONE);
    cyc(0, 4'h3, 4'h0, 4'h0, 1'b0, O_NONE);
    cyc(1, 4'h0, 4'h0, 4'h0, 1'b0, O_FETCH);
    cyc(1, 4'h0, 4'h0, 4'h0, 1'b0, O_NONE);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL rst_mem c%0d: got %h expected %h", i, g, e); end
    end
  endtask

  task automatic test_timeout();
    logic [12:0] e, g;
    cyc(1, 4'h0, 4'h0, 4'h0, 1'b0, O_FETCH);
    cyc(1, 4'h4, 4'h0, 4'h0, 1'b0, O_NONE);
    cyc(1, 4'h4, 4'h0, 4'h0, 1'b0, O_NONE);
    for (int k = 0; k < 16; k++) cyc(1, 4'h4, 4'h0, 4'h0, 1'b0, O_STR_MEM);
    cyc(1, 4'h1, 4'h0, 4'h0, 1'b1, O_FAULT);
    cyc(1, 4'h3, 4'h0, 4'h0, 1'b0, O_FAULT);
    cyc(1, 4'h0, 4'h0, 4'h0, 1'b1, O_FAULT);
    cyc(0, 4'h0, 4'h0, 4'h0, 1'b0, O_NONE);
    cyc(1, 4'h0, 4'h0, 4'h0, 1'b0, O_FETCH);
    cyc(1, 4'h0, 4'h0, 4'h0, 1'b0, O_NONE);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL timeout c%0d: got %h expected %h", i, g, e); end
    end
  endtask

  task automatic test_halt();
    logic [12:0] e, g;
    cyc(1, 4'h0, 4'h0, 4'h0, 1'b0, O_FETCH);
    cyc(1, 4'hF, 4'h0, 4'h0, 1'b0, O_NONE);
    cyc(1, 4'h1, 4'h2, 4'hF, 1'b1, O_HALT);
    cyc(1, 4'h3, 4'h0, 4'h0, 1'b0, O_HALT);
    cyc(1, 4'h4, 4'h0, 4'h0, 1'b1, O_HALT);
    cyc(1, 4'h0, 4'h0, 4'h0, 1'b0, O_HALT);
    cyc(0, 4'h0, 4'h0, 4'h0, 1'b0, O_NONE);
    cyc(1, 4'h0, 4'h0, 4'h0, 1'b0, O_FETCH);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL halt c%0d: got %h expected %h", i, g, e); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_f = 1'b0; opcode = 4'h0; mm = 4'h0; stat = 4'h0; dm_ack = 1'b0;
    test_reset();
    test_alu();
    test_branch();
    test_load();
    test_store();
    test_nop();
    test_reset_mid_mem();
    test_timeout();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sisc_seq.md
# sisc_seq

Multi-cycle instruction sequencer for the SISC datapath. Takes opcode/modifier fields of the current instruction and the status-register output. Drives every control strobe the register file, ALU, status register, write-back mux, PC and data memory need, one instruction at a time. Adds a data-memory request/acknowledge handshake with a bounded wait and a halt state, so it can replace the single-state control path.

## Interface
- `WAIT_MAX`, 15: maximum cycles MEM waits for `dm_ack` before faulting (1..255).
- `clk` in 1: rising-edge clock.
- `rst_f` in 1: asynchronous active-low reset.
- `opcode` in 4: instruction[31:28], valid while `ir_load` is low.
- `mm` in 4: instruction[27:24]; ALU function or branch condition mask.
- `stat` in 4: status register output.
- `dm_ack` in 1: data memory completed the current request.
- `ir_load` out 1: latch the next instruction into the IR.
- `pc_write` out 1: update PC.
- `pc_sel` out 1: 0 = PC+1, 1 = branch target.
- `rf_we` out 1: register-file write enable.
- `wb_sel` out 1: 0 = ALU result, 1 = memory data.
- `rb_sel` out 1: 0 = rt field, 1 = rd field (STR data).
- `alu_op` out 2: 00 address add, 01 branch target add, 10 function per `mm`, 11 unused.
- `stat_en` out 1: status-register load.
- `dm_req` out 1; `dm_we` out 1: data-memory request / write.
- `halted` out 1; `fault` out 1: sticky status flags.

## Operation
- Opcodes: 0x0 NOP, 0x1 ALU, 0x2 BRA, 0x3 LOD, 0x4 STR, 0xF HLT. Every other value decodes as NOP.
- States: FETCH, DECODE, EXEC, MEM, WBACK, HALT. Reset enters FETCH.
- **FETCH**
  - `ir_load`=1, `pc_write`=1, `pc_sel`=0.
  - Goes to DECODE.
- **DECODE**
  - No strobes.
  - NOP goes to FETCH, HLT goes to HALT, all others go to EXEC.
- **EXEC**
  - ALU: `alu_op`=10, `stat_en`=1, then WBACK.
  - LOD/STR: `alu_op`=00, then MEM.
  - BRA: `alu_op`=01. Taken when `mm`==0 or (`mm` & `stat`)!=0. If taken, `pc_write`=1 and `pc_sel`=1. Then FETCH.
- **MEM**
  - `dm_req`=1, `dm_we`=1 for STR only, `rb_sel`=1 for STR.
  - Wait counter clears on entry and increments each cycle `dm_ack` is low.
  - `dm_ack`=1 at an edge: LOD goes to WBACK, STR goes to FETCH.
  - Counter reaching `WAIT_MAX` with no ack: set `fault` and go to HALT.
- **WBACK**
  - `rf_we`=1. `wb_sel`=1 for LOD, 0 for ALU.
  - Goes to FETCH.
- **HALT**
  - All strobes 0, `halted`=1.
  - Left only by reset.
- Opcode and `mm` are captured in DECODE. Later states use the captured copy, so IR changes after DECODE are ignored.

## Timing
- Outputs are decoded from registered state and captured fields only. There is no combinational path from `dm_ack`, `opcode` or `stat` to any output, except the BRA taken decision, which samples `stat` in EXEC.
- Reset (async, any state, including mid-MEM): state=FETCH, counter=0, `halted`=0, `fault`=0.
  - The first cycle after release is FETCH, with `ir_load`=1.
  - While `rst_f`=0, every output is 0. `ir_load` and `pc_write` are forced low until release.
- Cycles per instruction:
  - NOP: 2.
  - BRA: 3.
  - ALU: 4.
  - STR: 4+w.
  - LOD: 5+w, where w = low-ack wait cycles.
- `dm_req` stays high every MEM cycle, including the ack cycle, and drops the cycle after.
- `dm_ack` outside MEM is ignored.
- Ack on the same edge the counter hits `WAIT_MAX`: ack wins, no fault.
- `stat_en` is only ever high in ALU EXEC. `rf_we` is only high in WBACK.

## Structure
- `sisc_pkg`: opcode constants, state enum, `alu_op` codes, `WB_ALU`/`WB_MEM`.
- One sub-module, `mem_wait_timer`: clear/enable counter with a terminal flag, width from `WAIT_MAX`.
- The rest is a single FSM plus output decode in `sisc_seq`.

## Test plan
- Reset mid-MEM (`dm_ack` held 0, drop `rst_f`) -> all outputs 0 immediately; after release the first cycle has `ir_load`=1, `dm_req`=0, `fault`=0.
- ALU opcode 0x1, `mm`=0x2 -> cycles 1-4:
  - cycle 1: `ir_load`
  - cycle 2: none
  - cycle 3: `alu_op`=10 with `stat_en`
  - cycle 4: `rf_we`=1, `wb_sel`=0
  - cycle 5: `ir_load` again.
- BRA with `mm`=0x4:
  - `stat`=0x4 -> EXEC `pc_write`=1, `pc_sel`=1.
  - `stat`=0x2 -> EXEC `pc_write`=0. Both return to FETCH at cycle 4.
- LOD with `dm_ack` after 3 low cycles -> `dm_req` high 4 cycles, then `rf_we`=1 with `wb_sel`=1; total 8 cycles.
- STR with `dm_ack` never asserted, `WAIT_MAX`=15 -> `dm_req`/`dm_we`/`rb_sel` high until the counter reaches 15; then `fault`=1, `halted`=1, all strobes 0 until reset.
- HLT 0xF -> `halted`=1 from cycle 3; later opcodes and `dm_ack` pulses cause no strobes. Opcode 0x9 -> behaves as NOP (2 cycles).
